i2c_target: RTL and testbench

- I2C target (responder) for the on-board bus; the counterpart of the team's i2c_fsm initiator.
- Runs on the system clock and oversamples scl/sda; it never generates scl.
- Matches a 7-bit address and ACKs it. Write bytes go out on rx_byte/rx_valid. For reads, it supplies tx_byte on sda.
- Exposes state_info[3:0] for sevenseg debug display.

---
 rtl/i2c_target.sv | 225 ++++++++++++++++++++++
 tb/tb_i2c_target.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target: 7-bit address match, byte write/read, debug state_info
// Optional: define I2C_GLITCH_FILTER_EN for a 3-sample agreement filter on scl/sda.
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h48
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] tx_byte,
  output logic       tx_req,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       busy,
  output logic [3:0] state_info
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_WRITE     = 3'd3,
    S_WRITE_ACK = 3'd4,
    S_READ      = 3'd5,
    S_READ_ACK  = 3'd6,
    S_IGNORE    = 3'd7
  } state_t;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_s, sda_s, scl_p, sda_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  // Filtered level follows the synchronizer only once three consecutive samples agree.
  logic [1:0] scl_hist, sda_hist;
  logic       scl_f, sda_f;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_f    <= scl_s;
      sda_f    <= sda_s;
    end
  end

  assign scl_s = (scl_sync[1] == scl_hist[0] && scl_hist[0] == scl_hist[1]) ? scl_sync[1] : scl_f;
  assign sda_s = (sda_sync[1] == sda_hist[0] && sda_hist[0] == sda_hist[1]) ? sda_sync[1] : sda_f;
`else
  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_p <= scl_s;
      sda_p <= sda_s;
    end
  end

  logic start_ev, stop_ev, rise_ev, fall_ev;
  assign start_ev = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_ev  = scl_s & scl_p & ~sda_p & sda_s;
  assign rise_ev  = ~scl_p & scl_s;
  assign fall_ev  = scl_p & ~scl_s;

  state_t     state, state_n;
  logic [2:0] bit_cnt, cnt_n;
  logic       got8, got8_n;
  logic [7:0] shreg, shreg_n, tx_shift, tx_shift_n, rx_byte_n;
  logic       oe_n, rx_valid_n, tx_req_n, busy_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      bit_cnt  <= 3'd0;
      got8     <= 1'b0;
      shreg    <= 8'h00;
      tx_shift <= 8'h00;
      sda_oe   <= 1'b0;
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= cnt_n;
      got8     <= got8_n;
      shreg    <= shreg_n;
      tx_shift <= tx_shift_n;
      sda_oe   <= oe_n;
      rx_byte  <= rx_byte_n;
      rx_valid <= rx_valid_n;
      tx_req   <= tx_req_n;
      busy     <= busy_n;
    end
  end

  // got8 marks that the 8th RISE of a byte (or the master ACK) has been seen.
  always_comb begin
    state_n    = state;
    cnt_n      = bit_cnt;
    got8_n     = got8;
    shreg_n    = shreg;
    tx_shift_n = tx_shift;
    oe_n       = sda_oe;
    rx_byte_n  = rx_byte;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    busy_n     = busy;
    if (start_ev) begin
      state_n = S_ADDR;
      cnt_n   = 3'd0;
      got8_n  = 1'b0;
      busy_n  = 1'b1;
      oe_n    = 1'b0;
    end else if (stop_ev) begin
      state_n = S_IDLE;
      cnt_n   = 3'd0;
      got8_n  = 1'b0;
      busy_n  = 1'b0;
      oe_n    = 1'b0;
    end else if (rise_ev) begin
      case (state)
        S_ADDR, S_WRITE: begin
          shreg_n = {shreg[6:0], sda_s};
          cnt_n   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            got8_n = 1'b1;
            if (state == S_WRITE) begin
              rx_byte_n  = {shreg[6:0], sda_s};
              rx_valid_n = 1'b1;
            end
          end
        end
        S_READ: begin
          cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) got8_n = 1'b1;
        end
        S_READ_ACK: begin
          if (sda_s) state_n = S_IGNORE;
          else       got8_n  = 1'b1;
        end
        default: ;
      endcase
    end else if (fall_ev) begin
      case (state)
        S_ADDR: begin
          if (got8) begin
            got8_n = 1'b0;
            if (shreg[7:1] == ADDR) begin
              oe_n    = 1'b1;
              state_n = S_ADDR_ACK;
            end else begin
              state_n = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (shreg[0]) begin
            tx_shift_n = tx_byte;
            tx_req_n   = 1'b1;
            oe_n       = ~tx_byte[7];
            state_n    = S_READ;
          end else begin
            oe_n    = 1'b0;
            state_n = S_WRITE;
          end
        end
        S_WRITE: begin
          if (got8) begin
            got8_n  = 1'b0;
            oe_n    = 1'b1;
            state_n = S_WRITE_ACK;
          end
        end
        S_WRITE_ACK: begin
          oe_n    = 1'b0;
          cnt_n   = 3'd0;
          state_n = S_WRITE;
        end
        S_READ: begin
          if (got8) begin
            got8_n  = 1'b0;
            oe_n    = 1'b0;
            state_n = S_READ_ACK;
          end else begin
            oe_n = ~tx_shift[3'd7 - bit_cnt];
          end
        end
        S_READ_ACK: begin
          if (got8) begin
            got8_n     = 1'b0;
            tx_shift_n = tx_byte;
            tx_req_n   = 1'b1;
            oe_n       = ~tx_byte[7];
            state_n    = S_READ;
          end
        end
        default: ;
      endcase
    end
  end

  assign state_info = {1'b0, state};

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - scoreboard bench for i2c_target driving an open-drain I2C bus model
module tb_i2c_target;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_drv, sda_drv;
  logic       sda_bus;
  logic       sda_oe, tx_req, rx_valid, busy;
  logic [7:0] tx_byte, rx_byte;
  logic [3:0] state_info;

  always #5 clk = ~clk;

  assign sda_bus = sda_drv & ~sda_oe;

  i2c_target #(.ADDR(7'h48)) dut (
    .clk(clk),
    .reset(reset),
    .scl_in(scl_drv),
    .sda_in(sda_bus),
    .sda_oe(sda_oe),
    .tx_byte(tx_byte),
    .tx_req(tx_req),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .busy(busy),
    .state_info(state_info)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_rd[$];
  int rx_cnt = 0;
  int txreq_cnt = 0;
  int oe_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write scoreboard: every rx_valid pops the byte queued when it was driven.
  always @(negedge clk) begin
    if (sda_oe) oe_cnt++;
    if (tx_req) txreq_cnt++;
    if (rx_valid) begin
      rx_cnt++;
      check("rx_expected", {31'b0, exp_rx.size() != 0}, 32'd1);
      if (exp_rx.size() != 0) check("rx_byte", rx_byte, exp_rx.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_drv = 1'b1; wait_clk(T);
    scl_drv = 1'b1; wait_clk(T);
    sda_drv = 1'b0; wait_clk(T);
    scl_drv = 1'b0;
  endtask

  task automatic i2c_stop;
    sda_drv = 1'b0; wait_clk(T);
    scl_drv = 1'b1; wait_clk(T);
    sda_drv = 1'b1; wait_clk(T);
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b;    wait_clk(T);
    scl_drv = 1'b1; wait_clk(T);
    scl_drv = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_drv = 1'b1; wait_clk(T);
    scl_drv = 1'b1; wait_clk(T / 2);
    ack = ~sda_bus; wait_clk(T / 2);
    scl_drv = 1'b0;
  endtask

  task automatic read_byte(output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      sda_drv = 1'b1; wait_clk(T);
      scl_drv = 1'b1; wait_clk(T / 2);
      d[i] = sda_bus; wait_clk(T / 2);
      scl_drv = 1'b0;
    end
    check("rd_queue", {31'b0, exp_rd.size() != 0}, 32'd1);
    if (exp_rd.size() != 0) check("rd_byte", d, exp_rd.pop_front());
  endtask

  task automatic send_ack(input logic ack);
    send_bit(~ack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         rx0, tx0, oe0;

    reset = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1; tx_byte = 8'h00;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(2);
    check("rst_state", state_info, 4'd0);
    check("rst_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_pulses", {rx_valid, tx_req}, 2'b00);

    // Plain write of one byte
    rx0 = rx_cnt;
    i2c_start(); wait_clk(T);
    check("wr_busy", busy, 1'b1);
    check("wr_state_addr", state_info, 4'd1);
    send_byte(8'h90, ack); check("wr_addr_ack", ack, 1'b1);
    exp_rx.push_back(8'hA5);
    send_byte(8'hA5, ack); check("wr_data_ack", ack, 1'b1);
    i2c_stop();
    check("wr_busy_end", busy, 1'b0);
    check("wr_state_end", state_info, 4'd0);
    check("wr_rx_count", rx_cnt - rx0, 1);

    // Read with NACK
    tx0 = txreq_cnt;
    tx_byte = 8'h3C;
    i2c_start();
    send_byte(8'h91, ack); check("rd_addr_ack", ack, 1'b1);
    exp_rd.push_back(8'h3C);
    read_byte(d);
    send_ack(1'b0); wait_clk(T);
    check("rd_state_nack", state_info, 4'd7);
    check("rd_oe_nack", sda_oe, 1'b0);
    i2c_stop();
    check("rd_txreq_count", txreq_cnt - tx0, 1);
    check("rd_state_end", state_info, 4'd0);

    // Address mismatch
    rx0 = rx_cnt; oe0 = oe_cnt;
    i2c_start();
    send_byte(8'h92, ack); check("mm_addr_nack", ack, 1'b0);
    check("mm_state", state_info, 4'd7);
    send_byte(8'h55, ack); check("mm_data_nack", ack, 1'b0);
    check("mm_state2", state_info, 4'd7);
    i2c_stop();
    check("mm_oe_cycles", oe_cnt - oe0, 0);
    check("mm_rx_count", rx_cnt - rx0, 0);
    check("mm_state_end", state_info, 4'd0);

    // Write then repeated start into a two-byte read
    tx0 = txreq_cnt;
    i2c_start();
    send_byte(8'h90, ack); check("sr_addr_w_ack", ack, 1'b1);
    exp_rx.push_back(8'h01);
    send_byte(8'h01, ack); check("sr_data_ack", ack, 1'b1);
    i2c_start(); wait_clk(T);
    check("sr_state_addr", state_info, 4'd1);
    send_byte(8'h91, ack); check("sr_addr_r_ack", ack, 1'b1);
    tx_byte = 8'h3C;
    exp_rd.push_back(8'h3C);
    read_byte(d);
    tx_byte = 8'hC3;
    exp_rd.push_back(8'hC3);
    send_ack(1'b1);
    read_byte(d);
    send_ack(1'b0);
    i2c_stop();
    check("sr_rx_byte", rx_byte, 8'h01);
    check("sr_txreq_count", txreq_cnt - tx0, 2);

    // Reset while the target drives a low read bit
    tx_byte = 8'h00;
    i2c_start();
    send_byte(8'h91, ack); check("rr_addr_ack", ack, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    sda_drv = 1'b1; wait_clk(T);
    scl_drv = 1'b1; wait_clk(T / 2);
    check("rr_oe_before", sda_oe, 1'b1);
    reset = 1'b1;
    wait_clk(1);
    check("rr_oe_after", sda_oe, 1'b0);
    check("rr_state_after", state_info, 4'd0);
    reset = 1'b0;
    wait_clk(T);
    scl_drv = 1'b0; wait_clk(T);
    i2c_start();
    send_byte(8'h90, ack); check("rr_addr_ack2", ack, 1'b1);
    exp_rx.push_back(8'h11);
    send_byte(8'h11, ack); check("rr_data_ack2", ack, 1'b1);
    i2c_stop();

    // 2-clk SCL low glitch in the high phase of the first data bit
    rx0 = rx_cnt;
    i2c_start();
    send_byte(8'h90, ack); check("gl_addr_ack", ack, 1'b1);
`ifdef I2C_GLITCH_FILTER_EN
    exp_rx.push_back(8'h55);
`else
    exp_rx.push_back(8'h2A);
`endif
    sda_drv = 1'b0; wait_clk(T);
    scl_drv = 1'b1; wait_clk(3);
    scl_drv = 1'b0; wait_clk(2);
    scl_drv = 1'b1; wait_clk(T - 5);
    scl_drv = 1'b0;
    for (int i = 6; i >= 0; i--) send_bit(i[0] ? 1'b0 : 1'b1);
    sda_drv = 1'b1; wait_clk(T);
    scl_drv = 1'b1; wait_clk(T);
    scl_drv = 1'b0;
    i2c_stop();
    check("gl_rx_count", rx_cnt - rx0, 1);
    check("gl_state_end", state_info, 4'd0);

    wait_clk(T);
    check("sb_rx_drained", exp_rx.size(), 0);
    check("sb_rd_drained", exp_rd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
